// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state encoding and widths for the restoring divider
package div_unit_pkg;
  localparam int DIV_DATA_W = 32;
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring step; ports rem_i/bit_i/divisor_i in, rem_o/quot_bit_o out
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              bit_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              quot_bit_o
);
  logic [DATA_W:0] part, diff;
  assign part = {rem_i, bit_i};
  assign diff = part - {1'b0, divisor_i};
  assign quot_bit_o = ~diff[DATA_W];
  assign rem_o = quot_bit_o ? diff[DATA_W-1:0] : part[DATA_W-1:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring DIV/DIVU; clk,rst,signed_div_i,opdata1_i,opdata2_i,start_i,annul_i in; result_o {rem,quot},ready_o out
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  div_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] dvd, dvs, rem, quot, step_rem, q_final, op1_abs, op2_abs;
  logic [2*DATA_W-1:0] res_q;
  logic q_neg, r_neg, step_q, op1_neg, op2_neg, accept, last;
  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_abs = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_abs = op2_neg ? -opdata2_i : opdata2_i;
  assign accept = (state == DIV_FREE) && start_i && !annul_i;
  assign last = cnt == CNT_W'(DATA_W - 1);
  assign q_final = {quot[DATA_W-2:0], step_q};
  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i(rem),
    .bit_i(dvd[DATA_W-1]),
    .divisor_i(dvs),
    .rem_o(step_rem),
    .quot_bit_o(step_q)
  );
  always_ff @(posedge clk)
    if (rst) state <= DIV_FREE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      DIV_FREE:    state_nxt = accept ? (opdata2_i == '0 ? DIV_BY_ZERO : DIV_ON) : DIV_FREE;
      DIV_BY_ZERO: state_nxt = DIV_END;
      DIV_ON:      state_nxt = annul_i ? DIV_FREE : (last ? DIV_END : DIV_ON);
      DIV_END:     state_nxt = (!start_i || annul_i) ? DIV_FREE : DIV_END;
    endcase
  end
  always_comb begin
    ready_o = state == DIV_END;
    result_o = ready_o ? res_q : '0;
  end
  // sign fix is applied on the final step so res_q is ready when END is entered
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      quot <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      res_q <= '0;
    end else if (accept) begin
      cnt <= '0;
      dvd <= op1_abs;
      dvs <= op2_abs;
      rem <= '0;
      quot <= '0;
      q_neg <= op1_neg ^ op2_neg;
      r_neg <= op1_neg;
      res_q <= '0;
    end else if (state == DIV_ON && !annul_i) begin
      cnt <= cnt + 1'b1;
      dvd <= dvd << 1;
      rem <= step_rem;
      quot <= q_final;
      if (last) res_q <= {r_neg ? -step_rem : step_rem, q_neg ? -q_final : q_final};
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an arithmetic reference
module tb_div_unit;
  logic clk, rst, signed_div_i, start_i, annul_i, ready_o;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  int checks = 0, errors = 0;
  div_unit #(.DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i),
    .start_i(start_i),
    .annul_i(annul_i),
    .result_o(result_o),
    .ready_o(ready_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
    if (!s) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int n, lat;
    exp = ref_div(s, a, b);
    lat = (b == 0) ? 2 : 33;
    signed_div_i = s;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
    n = 0;
    while (!ready_o && n < 40) begin
      step();
      n++;
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      signed_div_i = 1'($urandom);
    end
    chk("latency", 64'(n), 64'(lat));
    chk("result", result_o, exp);
    step();
    chk("hold_ready", 64'(ready_o), 64'd1);
    chk("hold_result", result_o, exp);
    start_i = 1'b0;
    step();
    chk("drop_ready", 64'(ready_o), 64'd0);
    chk("drop_result", result_o, 64'd0);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int seen;
    rst = 1'b1;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    step();
    step();
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    rst = 1'b0;
    step();
    do_op(1'b0, 32'd100, 32'd7);
    chk("divu_100_7", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    do_op(1'b1, -32'sd7, 32'd2);
    do_op(1'b1, 32'd7, -32'sd2);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b0, 32'd5, 32'd0);
    do_op(1'b1, 32'hFFFF_FFFF, 32'd0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    do_op(1'b0, 32'd3, 32'd9);
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    annul_i = 1'b1;
    start_i = 1'b0;
    step();
    annul_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o) seen++;
      step();
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    do_op(1'b0, 32'd9, 32'd3);
    opdata1_i = 32'd1000;
    opdata2_i = 32'd10;
    start_i = 1'b1;
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    start_i = 1'b0;
    step();
    chk("rst_mid_ready", 64'(ready_o), 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    rst = 1'b0;
    do_op(1'b1, -32'sd1000, 32'd10);
    signed_div_i = 1'b0;
    opdata1_i = 32'd50;
    opdata2_i = 32'd0;
    start_i = 1'b1;
    step();
    step();
    chk("end_ready", 64'(ready_o), 64'd1);
    annul_i = 1'b1;
    step();
    chk("end_annul_ready", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    step();
    for (int i = 0; i < 40; i++) do_op(1'($urandom), pick(), pick());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
